// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU/mux
// select codes, instruction fields and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unsupported data-processing commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation from the registered {N,Z,C,V} flags.
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags_i[3];
    assign z = flags_i[2];
    assign c = flags_i[1];
    assign v = flags_i[0];

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0; // 1111 never executes
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences the shared ALU and unified memory port,
// holds condition flags and maintains cycle / retired-instruction counters.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ALUControl,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] instr_cnt_d;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       cond_ex;
    logic       flag_upd;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       unused_instr_bits;

    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    cond_check u_cond_check (
        .cond_i    (Instr[31:28]),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        flag_upd   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU computes PC+8 here so R15 reads see the ARM pipeline value.
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (!cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_DP:   state_d = Instr[25] ? S_EXECI : S_EXECR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                reg_write = 1'b1;
                pc_write  = rd_is_pc;
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                ALUControl = alu_decode(cmd);
                flag_upd   = Instr[20];
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                pc_write  = rd_is_pc;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Logical ops leave C and V alone; only ADD/SUB produce meaningful carry/overflow.
    always_comb begin
        flags_d = flags_q;
        if (flag_upd) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (cmd == CMD_ADD || cmd == CMD_SUB) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        instr_cnt_d = instr_cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH) instr_cnt_d = instr_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            flags_q     <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Strobes are masked while reset is held so an aborted access never writes.
    assign PCWrite  = pc_write  & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign RegWrite = reg_write & ~reset;

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule
